// File: rtl/sp_fifo_ctrl_pkg.sv
// Shared constants and types for the single-port FIFO controller.
// Depth/width helpers are functions so each instance derives them from its own ADDR_LEN.
package sp_fifo_ctrl_pkg;

  localparam int unsigned DEF_DATA_LEN = 32'd32;
  localparam int unsigned DEF_ADDR_LEN = 32'd2;

  // What the single matrix port is doing this cycle
  typedef enum logic [1:0] {
    OP_IDLE = 2'd0,
    OP_WR   = 2'd1,
    OP_RD   = 2'd2,
    OP_BYP  = 2'd3
  } port_op_e;

  function automatic int unsigned fifo_depth(input int unsigned addr_len);
    return 32'd1 << addr_len;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned addr_len);
    return addr_len + 32'd1;
  endfunction

endpackage

// File: rtl/sp_fifo_ptr.sv
// Wrapping ADDR_LEN-bit pointer with synchronous clear (priority) and increment.
module sp_fifo_ptr #(
  parameter int unsigned ADDR_LEN = 32'd2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                inc,
  output logic [ADDR_LEN-1:0] ptr
);

  // Pointer register, wraps modulo 2**ADDR_LEN by natural overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= {ADDR_LEN{1'b0}};
    end else if (clr) begin
      ptr <= {ADDR_LEN{1'b0}};
    end else if (inc) begin
      ptr <= ptr + ADDR_LEN'(1'b1);
    end else begin
      ptr <= ptr;
    end
  end

endmodule

// File: rtl/sp_fifo_ctrl.sv
// Valid/ready FIFO controller for a single-port flop matrix with an empty-bypass output slot.
// Optional high-watermark output enabled by defining SP_FIFO_HWM_EN.
module sp_fifo_ctrl
  import sp_fifo_ctrl_pkg::*;
#(
  parameter int unsigned DATA_LEN = DEF_DATA_LEN,
  parameter int unsigned ADDR_LEN = DEF_ADDR_LEN
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_LEN-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_LEN-1:0] out_data,
  output logic                mem_wen,
  output logic [ADDR_LEN-1:0] mem_addr,
  output logic [DATA_LEN-1:0] mem_wdata,
  input  logic [DATA_LEN-1:0] mem_rdata,
  output logic [ADDR_LEN:0]   level
`ifdef SP_FIFO_HWM_EN
  ,
  output logic [ADDR_LEN:0]   hwm
`endif
);

  localparam int unsigned      CNT_W    = cnt_width(ADDR_LEN);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(fifo_depth(ADDR_LEN));
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

  logic [CNT_W-1:0]    cnt_r;
  logic [CNT_W-1:0]    cnt_nxt_s;
  logic                out_valid_r;
  logic [DATA_LEN-1:0] out_data_r;
  logic [ADDR_LEN-1:0] wptr_s;
  logic [ADDR_LEN-1:0] rptr_s;
  logic                pop_s;
  logic                slot_free_s;
  logic                rd_s;
  logic                byp_s;
  logic                wr_s;
  logic                in_ready_s;
  port_op_e            op_s;

  // Per-cycle port decode; a refill read always beats an enqueue
  always_comb begin
    pop_s       = out_valid_r & out_ready;
    slot_free_s = ~out_valid_r | pop_s;
    rd_s        = slot_free_s & (cnt_r != CNT_ZERO);
    byp_s       = slot_free_s & (cnt_r == CNT_ZERO) & in_valid;
    in_ready_s  = ~flush & ((slot_free_s & (cnt_r == CNT_ZERO)) |
                            (~rd_s & (cnt_r < DEPTH_C)));
    wr_s        = in_valid & in_ready_s & ~byp_s;
    if (rd_s) begin
      op_s = OP_RD;
    end else if (byp_s) begin
      op_s = OP_BYP;
    end else if (wr_s) begin
      op_s = OP_WR;
    end else begin
      op_s = OP_IDLE;
    end
  end

  // Next occupancy of the array (output slot not included)
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (flush) begin
      cnt_nxt_s = CNT_ZERO;
    end else begin
      case (op_s)
        OP_WR:   cnt_nxt_s = cnt_r + CNT_ONE;
        OP_RD:   cnt_nxt_s = cnt_r - CNT_ONE;
        default: cnt_nxt_s = cnt_r;
      endcase
    end
  end

  sp_fifo_ptr #(.ADDR_LEN(ADDR_LEN)) u_wptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (op_s == OP_WR),
    .ptr (wptr_s)
  );

  sp_fifo_ptr #(.ADDR_LEN(ADDR_LEN)) u_rptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (op_s == OP_RD),
    .ptr (rptr_s)
  );

  // Occupancy counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= CNT_ZERO;
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end

  // Output slot: refill from the array or bypass; flush keeps the data word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {DATA_LEN{1'b0}};
    end else if (flush) begin
      out_valid_r <= 1'b0;
    end else begin
      case (op_s)
        OP_RD: begin
          out_valid_r <= 1'b1;
          out_data_r  <= mem_rdata;
        end
        OP_BYP: begin
          out_valid_r <= 1'b1;
          out_data_r  <= in_data;
        end
        default: begin
          if (pop_s) begin
            out_valid_r <= 1'b0;
          end else begin
            out_valid_r <= out_valid_r;
          end
        end
      endcase
    end
  end

`ifdef SP_FIFO_HWM_EN
  logic [CNT_W-1:0] hwm_r;

  // High watermark of array occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hwm_r <= CNT_ZERO;
    end else if (flush) begin
      hwm_r <= CNT_ZERO;
    end else if (cnt_nxt_s > hwm_r) begin
      hwm_r <= cnt_nxt_s;
    end else begin
      hwm_r <= hwm_r;
    end
  end

  assign hwm = hwm_r;
`endif

  assign in_ready  = in_ready_s;
  assign mem_wen   = (op_s == OP_WR) & ~flush;
  assign mem_addr  = (op_s == OP_RD) ? rptr_s : wptr_s;
  assign mem_wdata = in_data;
  assign level     = cnt_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;

endmodule
